// File: rtl/ana_pad_pkg.sv
// ana_pad_pkg
// Shared types and defaults for the analog pad switch sequencer.
//   state_e         : sequencer states (OFF, BREAK, MAKE, ON)
//   DEF_NCH         : default number of pad switch channels
//   DEF_BBM_CYC     : default break-before-make gap in clock cycles
//   DEF_SETTLE_CYC  : default post-make settling time in clock cycles
//   cnt_width()     : width of the shared BREAK/MAKE down-counter
//   CW              : counter width for the default timing values
package ana_pad_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_ON    = 2'd3
  } state_e;

  localparam int DEF_NCH        = 4;
  localparam int DEF_BBM_CYC    = 4;
  localparam int DEF_SETTLE_CYC = 16;

  // The counter must hold the larger of the two reload values.
  function automatic int cnt_width(input int bbm, input int settle);
    int m;
    m = (bbm > settle) ? bbm : settle;
    return $clog2(m + 1);
  endfunction

  localparam int CW = cnt_width(DEF_BBM_CYC, DEF_SETTLE_CYC);

endpackage

// File: rtl/ana_pad_mux_seq_sync2.sv
// ana_sync2
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, both flops clear to 0
//   d_i    : asynchronous input level
//   q_o    : synchronized level, two clock edges behind d_i
module ana_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ana_pad_mux_seq.sv
// ana_pad_mux_seq
// Break-before-make sequencer for a bank of analog pad switches. A request
// for a new channel opens every switch for BBM_CYC cycles, closes the
// selected switch, waits SETTLE_CYC cycles, then reports SETTLED. Loss of
// the analog supply (PWR_OK, synchronized) forces all switches open.
//
// Ports:
//   CLK         : clock, rising edge
//   RN          : asynchronous active-low reset
//   PWR_OK      : analog supply power-good, asynchronous to CLK
//   SEL_VALID   : selection request valid
//   SEL_CH      : requested channel; one bit wider than ACT_CH so that
//                 out-of-range indices can be presented and flagged
//   SEL_OFF     : request all switches open (SEL_CH ignored)
//   SEL_READY   : request acceptance
//   SW_EN       : one-hot-or-zero switch enables
//   ACT_CH      : index of the enabled or pending channel
//   SETTLED     : selected switch closed and settling time elapsed
//   SEL_ERR     : one-cycle pulse, accepted request was out of range
//   dbg_state_o : current sequencer state
//
// Handshake: a request is taken on a rising CLK edge where SEL_VALID and
// SEL_READY are both high. SEL_READY is high only in OFF or ON with
// power-good; SEL_VALID is never queued while SEL_READY is low. A request
// taken in the cycle where power-good falls is superseded by the shutdown.
module ana_pad_mux_seq
  import ana_pad_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int BBM_CYC    = DEF_BBM_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  localparam int ACW       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int SCW       = ACW + 1
) (
  input  logic           CLK,
  input  logic           RN,
  input  logic           PWR_OK,
  input  logic           SEL_VALID,
  input  logic [SCW-1:0] SEL_CH,
  input  logic           SEL_OFF,
  output logic           SEL_READY,
  output logic [NCH-1:0] SW_EN,
  output logic [ACW-1:0] ACT_CH,
  output logic           SETTLED,
  output logic           SEL_ERR,
  output state_e         dbg_state_o
);

  localparam int             CNT_W       = cnt_width(BBM_CYC, SETTLE_CYC);
  localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   sw_en_q, sw_en_d;
  logic [ACW-1:0]   act_ch_q, act_ch_d;
  logic             settled_q, settled_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic pwr_ok_s;
  logic accept;
  logic req_oob;
  logic req_same;
  logic new_sel;
  logic cnt_zero;

  ana_sync2 u_pwr_sync (
    .clk_i  (CLK),
    .rst_ni (RN),
    .d_i    (PWR_OK),
    .q_o    (pwr_ok_s)
  );

  assign accept   = SEL_VALID && ready_q;
  assign req_oob  = (SEL_CH >= SCW'(NCH));
  assign req_same = (SEL_CH == {1'b0, act_ch_q});
  assign cnt_zero = (cnt_q == '0);

  // A channel request restarts break-before-make unless it names the channel
  // that is already settled; re-selecting from OFF always goes through BREAK.
  assign new_sel = accept && !SEL_OFF && !req_oob &&
                   !((state_q == ST_ON) && req_same);

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      sw_en_q   <= '0;
      act_ch_q  <= '0;
      settled_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_en_q   <= sw_en_d;
      act_ch_q  <= act_ch_d;
      settled_q <= settled_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  // Next state and shared BREAK/MAKE down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!pwr_ok_s) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF, ST_ON: begin
          if (accept && SEL_OFF) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (new_sel) begin
            state_d = ST_BREAK;
            cnt_d   = BBM_LOAD;
          end
        end
        ST_BREAK: begin
          if (cnt_zero) begin
            state_d = ST_MAKE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_MAKE: begin
          if (cnt_zero) begin
            state_d = ST_ON;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    sw_en_d   = sw_en_q;
    act_ch_d  = act_ch_q;
    settled_d = settled_q;
    err_d     = 1'b0;
    if (!pwr_ok_s) begin
      sw_en_d   = '0;
      settled_d = 1'b0;
    end else begin
      case (state_q)
        ST_OFF, ST_ON: begin
          if (accept) begin
            if (SEL_OFF) begin
              sw_en_d   = '0;
              settled_d = 1'b0;
            end else if (req_oob) begin
              err_d = 1'b1;
            end else if (new_sel) begin
              sw_en_d   = '0;
              settled_d = 1'b0;
              act_ch_d  = SEL_CH[ACW-1:0];
            end
          end
        end
        ST_BREAK: begin
          // Switches are all open here, so closing one cannot overlap.
          if (cnt_zero) begin
            sw_en_d = NCH'(1) << act_ch_q;
          end
        end
        ST_MAKE: begin
          if (cnt_zero) begin
            settled_d = 1'b1;
          end
        end
        default: begin
          sw_en_d   = '0;
          settled_d = 1'b0;
        end
      endcase
    end
    // Registered copy of "OFF/ON with power-good" for the state being entered.
    ready_d = pwr_ok_s && ((state_d == ST_OFF) || (state_d == ST_ON));
  end

  assign SEL_READY   = ready_q;
  assign SW_EN       = sw_en_q;
  assign ACT_CH      = act_ch_q;
  assign SETTLED     = settled_q;
  assign SEL_ERR     = err_q;
  assign dbg_state_o = state_q;

endmodule
